// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C slave front end: defaults and the byte-level FSM states.
package i2c_pkg;

  localparam logic [6:0]  I2C_ADDRESS_DEFAULT = 7'h3C;
  localparam int unsigned FILTER_LEN_DEFAULT  = 4;

  // ACK_REG / ACK_WR / RD_LOAD are the one-SCL-period phases between bytes
  // where the slave drives (or prepares to drive) the ninth bit.
  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DEV_ADDR,
    ST_ACK_DEV,
    ST_REG_ADDR,
    ST_ACK_REG,
    ST_WRITE,
    ST_ACK_WR,
    ST_READ,
    ST_RD_ACK,
    ST_RD_LOAD,
    ST_IDLE_WAIT
  } state_e;

endpackage

// File: rtl/i2c_line_filter.sv
// Two-flop synchronizer plus stability filter for one open-drain line.
// The filtered level only moves after FILTER_LEN consecutive differing
// samples; rise/fall pulse for one clk in the cycle the level changes.
module i2c_line_filter #(
  parameter int unsigned FILTER_LEN = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic line_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned     CW       = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CW-1:0]   CNT_MAX  = CW'(FILTER_LEN - 1);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic          level_q, level_d;
  logic          rise_q,  rise_d;
  logic          fall_q,  fall_d;

  // Stability counter: count samples that disagree with the filtered level.
  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path can leave it unassigned and infer a latch.
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (sync_q[1] == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d   = '0;
      level_d = sync_q[1];
      rise_d  = sync_q[1];
      fall_d  = ~sync_q[1];
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // Synchronizer and filter state; an idle I2C line is high, so reset to 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 2'b11;
      cnt_q   <= '0;
      level_q <= 1'b1;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here, so every flop samples the values from before the edge.
      sync_q  <= {sync_q[0], line_i};
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/i2c_slave_serial.sv
// Byte-level I2C slave feeding a register interface: pointer writes,
// auto-incrementing burst writes and repeated-start burst reads.
// SDA is only ever pulled low (open drain); SCL is never driven.
module i2c_slave_serial
  import i2c_pkg::*;
#(
  parameter logic [6:0]  I2C_ADDRESS = I2C_ADDRESS_DEFAULT,
  parameter int unsigned FILTER_LEN  = FILTER_LEN_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_wen,
  input  logic [7:0] reg_rdata,
  output logic       busy
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
    .clk     (clk),
    .rst_n   (rst_n),
    .line_i  (scl_in),
    .level_o (scl_lvl),
    .rise_o  (scl_rise),
    .fall_o  (scl_fall)
  );

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
    .clk     (clk),
    .rst_n   (rst_n),
    .line_i  (sda_in),
    .level_o (sda_lvl),
    .rise_o  (sda_rise),
    .fall_o  (sda_fall)
  );

  state_e     state_q,     state_d;
  logic [3:0] bit_cnt_q,   bit_cnt_d;
  logic [7:0] shift_q,     shift_d;
  logic       rw_q,        rw_d;
  logic       sda_oe_q,    sda_oe_d;
  logic [7:0] reg_addr_q,  reg_addr_d;
  logic [7:0] reg_wdata_q, reg_wdata_d;
  logic       reg_wen_q,   reg_wen_d;
  logic       busy_q,      busy_d;

  logic       start_det, stop_det;
  logic [7:0] rx_byte;

  // SDA may only change while SCL is low, so an SDA edge with SCL high is a bus condition.
  assign start_det = sda_fall & scl_lvl;
  assign stop_det  = sda_rise & scl_lvl;
  // Byte as it stands once the current bit is shifted in, MSB first.
  assign rx_byte   = {shift_q[6:0], sda_lvl};

  // Next-state and output decode; START/STOP pre-empt every state.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    rw_d        = rw_q;
    sda_oe_d    = sda_oe_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_wen_d   = 1'b0;
    busy_d      = busy_q;

    // Post-write auto-increment lands on the clk after the strobe.
    if (reg_wen_q) reg_addr_d = reg_addr_q + 8'd1;

    if (start_det) begin
      state_d   = ST_DEV_ADDR;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b1;
    end else if (stop_det) begin
      state_d  = ST_IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      case (state_q)
        ST_DEV_ADDR: begin
          if (scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              if (rx_byte[7:1] == I2C_ADDRESS) rw_d    = rx_byte[0];
              else                             state_d = ST_IDLE;
            end
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            sda_oe_d = 1'b1;
            state_d  = ST_ACK_DEV;
          end
        end
        ST_ACK_DEV: begin
          if (scl_fall) begin
            if (rw_q) begin
              sda_oe_d  = ~reg_rdata[7];
              shift_d   = {reg_rdata[6:0], 1'b0};
              bit_cnt_d = 4'd1;
              state_d   = ST_READ;
            end else begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = '0;
              state_d   = ST_REG_ADDR;
            end
          end
        end
        ST_REG_ADDR: begin
          if (scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) reg_addr_d = rx_byte;
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            sda_oe_d = 1'b1;
            state_d  = ST_ACK_REG;
          end
        end
        ST_WRITE: begin
          if (scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              reg_wdata_d = rx_byte;
              reg_wen_d   = 1'b1;
            end
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            sda_oe_d = 1'b1;
            state_d  = ST_ACK_WR;
          end
        end
        ST_ACK_REG, ST_ACK_WR: begin
          if (scl_fall) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = '0;
            state_d   = ST_WRITE;
          end
        end
        ST_READ: begin
          // bit_cnt counts bits already placed on SDA.
          if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              sda_oe_d = 1'b0;
              state_d  = ST_RD_ACK;
            end else begin
              sda_oe_d  = ~shift_q[7];
              shift_d   = {shift_q[6:0], 1'b0};
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end
        ST_RD_ACK: begin
          if (scl_rise) begin
            if (!sda_lvl) begin
              reg_addr_d = reg_addr_q + 8'd1;
              state_d    = ST_RD_LOAD;
            end else begin
              state_d = ST_IDLE_WAIT;
            end
          end
        end
        ST_RD_LOAD: begin
          // Half an SCL period has passed since the increment, so reg_rdata has caught up.
          if (scl_fall) begin
            sda_oe_d  = ~reg_rdata[7];
            shift_d   = {reg_rdata[6:0], 1'b0};
            bit_cnt_d = 4'd1;
            state_d   = ST_READ;
          end
        end
        default: ;  // IDLE and IDLE_WAIT only leave on START/STOP
      endcase
    end
  end

  // State and output registers; outputs come straight from flops so reset clears them without a clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      rw_q        <= 1'b0;
      sda_oe_q    <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      reg_wen_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      rw_q        <= rw_d;
      sda_oe_q    <= sda_oe_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_wen_q   <= reg_wen_d;
      busy_q      <= busy_d;
    end
  end

  assign sda_oe    = sda_oe_q;
  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;
  assign reg_wen   = reg_wen_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_slave_serial.sv
// Self-checking bench: a bit-banged I2C master, a register-file model on the
// register interface, and a scoreboard of expected write strobes.
module tb_i2c_slave_serial;
  import i2c_pkg::*;

  localparam logic [6:0] DEV = 7'h3C;
  localparam int         Q   = 8;   // clks per quarter SCL period

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_bus;
  logic       sda_oe;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;
  logic       reg_wen, busy;

  assign sda_bus = sda_m & ~sda_oe;   // wired-AND of master and slave

  always #5 clk = ~clk;

  i2c_slave_serial #(.I2C_ADDRESS(DEV), .FILTER_LEN(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl_in    (scl_m),
    .sda_in    (sda_bus),
    .sda_oe    (sda_oe),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_wen   (reg_wen),
    .reg_rdata (reg_rdata),
    .busy      (busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- register interface environment ----------------
  logic [7:0] bus_regs [256];
  logic       pl_en = 1'b0;
  logic [7:0] pl_addr = '0, pl_data = '0;

  always @(posedge clk) begin
    if (pl_en)        bus_regs[pl_addr]  <= pl_data;
    else if (reg_wen) bus_regs[reg_addr] <= reg_wdata;
    reg_rdata <= bus_regs[reg_addr];
  end

  // ---------------- reference model ----------------
  typedef struct packed { logic [7:0] addr; logic [7:0] data; } wr_t;
  wr_t        exp_wr [$];
  logic [7:0] mdl_regs [256];
  logic [7:0] mdl_ptr = '0;

  // ---------------- monitor: write strobes vs scoreboard ----------------
  logic prev_wen = 1'b0;
  int   oe_cnt   = 0;
  always @(negedge clk) begin
    if (sda_oe) oe_cnt++;
    if (reg_wen) begin
      check("wen_width", prev_wen, 1'b0);
      check("wen_pending", exp_wr.size() > 0, 1'b1);
      if (exp_wr.size() > 0) begin
        wr_t e;
        e = exp_wr.pop_front();
        check("wen_addr", reg_addr, e.addr);
        check("wen_data", reg_wdata, e.data);
      end
    end
    prev_wen = reg_wen;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // ---------------- master bus tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    mdl_regs[a] = d;
    tick(1);
    pl_en = 1'b0;
  endtask

  task automatic bus_start;
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic bus_stop;
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b1; tick(Q);
  endtask

  task automatic write_bit(input logic b);
    sda_m = b;    tick(Q);
    scl_m = 1'b1; tick(2*Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    b = sda_bus;  tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack_n);
    for (int i = 7; i >= 0; i--) write_bit(b[i]);
    read_bit(ack_n);
  endtask

  task automatic recv_byte(output logic [7:0] b, input logic nack);
    logic bt;
    for (int i = 7; i >= 0; i--) begin
      read_bit(bt);
      b[i] = bt;
    end
    write_bit(nack);
  endtask

  // Complete write transaction; expected strobes are queued before each byte goes out.
  task automatic xfer_write(input logic [7:0] ptr, input logic [7:0] d [4], input int n);
    logic ack_n;
    bus_start;
    check("busy_after_start", busy, 1'b1);
    send_byte({DEV, 1'b0}, ack_n); check("ack_dev_w", ack_n, 1'b0);
    send_byte(ptr, ack_n);         check("ack_reg", ack_n, 1'b0);
    mdl_ptr = ptr;
    for (int i = 0; i < n; i++) begin
      exp_wr.push_back('{addr: mdl_ptr, data: d[i]});
      mdl_regs[mdl_ptr] = d[i];
      mdl_ptr++;
      send_byte(d[i], ack_n);      check("ack_data", ack_n, 1'b0);
    end
    bus_stop;
    tick(4);
    check("reg_addr_after_wr", reg_addr, mdl_ptr);
    check("busy_after_stop", busy, 1'b0);
  endtask

  // Pointer write, repeated START, n-byte read ending with NACK.
  task automatic xfer_read(input logic [7:0] ptr, input int n);
    logic       ack_n;
    logic [7:0] b;
    bus_start;
    send_byte({DEV, 1'b0}, ack_n); check("ack_dev_w", ack_n, 1'b0);
    send_byte(ptr, ack_n);         check("ack_reg", ack_n, 1'b0);
    mdl_ptr = ptr;
    bus_start;
    send_byte({DEV, 1'b1}, ack_n); check("ack_dev_r", ack_n, 1'b0);
    for (int i = 0; i < n; i++) begin
      recv_byte(b, i == n - 1);
      check("rd_data", b, mdl_regs[mdl_ptr]);
      if (i != n - 1) mdl_ptr++;
    end
    check("oe_released_after_nack", sda_oe, 1'b0);
    bus_stop;
    tick(4);
    check("reg_addr_after_rd", reg_addr, mdl_ptr);
    check("busy_after_stop", busy, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] d [4];
    logic       ack_n;
    int         oe_before;
    logic [7:0] addr_byte;

    tick(3);
    check("rst_sda_oe", sda_oe, 1'b0);
    check("rst_reg_addr", reg_addr, 8'h00);
    check("rst_reg_wdata", reg_wdata, 8'h00);
    check("rst_reg_wen", reg_wen, 1'b0);
    check("rst_busy", busy, 1'b0);
    for (int i = 0; i < 256; i++) preload(8'(i), 8'($urandom));
    rst_n = 1'b1;
    tick(20);

    // single write at 0x82
    d = '{8'h05, 8'h00, 8'h00, 8'h00};
    xfer_write(8'h82, d, 1);

    // burst write wrapping through 0xFF
    d = '{8'h11, 8'h22, 8'h33, 8'h00};
    xfer_write(8'hFE, d, 3);

    // pointer 0xB3 then two-byte read, ACK then NACK
    preload(8'hB3, 8'hA5);
    preload(8'hB4, 8'h3C);
    xfer_read(8'hB3, 2);

    // foreign address: never acknowledged, no strobes
    oe_before = oe_cnt;
    bus_start;
    send_byte({7'h50, 1'b0}, ack_n); check("nack_foreign", ack_n, 1'b1);
    send_byte(8'hAA, ack_n);         check("nack_foreign_data", ack_n, 1'b1);
    check("state_idle_foreign", dut.state_q, ST_IDLE);
    bus_stop;
    tick(4);
    check("oe_never_foreign", oe_cnt - oe_before, 0);
    check("busy_after_foreign", busy, 1'b0);

    // 2-clk SCL glitch mid-byte must not add a bit; then STOP mid-byte
    bus_start;
    send_byte({DEV, 1'b0}, ack_n); check("ack_dev_w", ack_n, 1'b0);
    send_byte(8'h10, ack_n);       check("ack_reg", ack_n, 1'b0);
    exp_wr.push_back('{addr: 8'h10, data: 8'h96});
    mdl_regs[8'h10] = 8'h96;
    mdl_ptr = 8'h11;
    addr_byte = 8'h96;
    for (int i = 7; i >= 4; i--) write_bit(addr_byte[i]);
    scl_m = 1'b1; tick(2);
    scl_m = 1'b0; tick(2*Q);
    for (int i = 3; i >= 0; i--) write_bit(addr_byte[i]);
    read_bit(ack_n);               check("ack_after_glitch", ack_n, 1'b0);
    write_bit(1'b1); write_bit(1'b0); write_bit(1'b1);
    bus_stop;
    tick(4);
    check("busy_stop_midbyte", busy, 1'b0);
    check("state_stop_midbyte", dut.state_q, ST_IDLE);
    check("reg_addr_stop_midbyte", reg_addr, mdl_ptr);

    // asynchronous reset while the slave is driving the address ACK
    bus_start;
    addr_byte = {DEV, 1'b0};
    for (int i = 7; i >= 0; i--) write_bit(addr_byte[i]);
    sda_m = 1'b1; tick(Q);
    check("ack_driven_before_rst", sda_oe, 1'b1);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_sda_oe", sda_oe, 1'b0);
    check("async_rst_reg_addr", reg_addr, 8'h00);
    check("async_rst_busy", busy, 1'b0);
    scl_m = 1'b1; sda_m = 1'b1;
    tick(10);
    rst_n = 1'b1;
    mdl_ptr = 8'h00;
    tick(20);
    d = '{8'($urandom), 8'($urandom), 8'h00, 8'h00};
    xfer_write(8'h40, d, 2);
    xfer_read(8'h40, 2);

    // randomized mix of writes and reads
    for (int t = 0; t < 10; t++) begin
      logic [7:0] ptr;
      int         n;
      ptr = 8'($urandom);
      n   = $urandom_range(1, 3);
      if ($urandom_range(0, 1) == 0) begin
        for (int k = 0; k < 4; k++) d[k] = 8'($urandom);
        xfer_write(ptr, d, n);
      end else begin
        xfer_read(ptr, n);
      end
    end

    tick(20);
    check("wr_queue_drained", exp_wr.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
